rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter_pkg.sv | 17 +
 rtl/n_1_mux.sv | 23 ++
 rtl/rr_mux_arbiter_rr_grant.sv | 33 +++
 rtl/rr_mux_arbiter.sv | 96 +++++++++
 tb/tb_rr_mux_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Output-buffer state encoding and select-width helper.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } buf_state_e;

  localparam int unsigned MinRequesters = 2;

  // Width of a select that indexes n requesters; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n_1_mux.sv
// N:1 word multiplexer over a packed input bus; word i sits at [i*WIDTH +: WIDTH].
module n_1_mux
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned SelW = sel_w(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SelW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data
);

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel) == i) begin
        out_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_rr_grant.sv
// Round-robin priority encoder: first valid requester scanning from ptr upward, wrapping.
module rr_grant
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  localparam int unsigned SelW = sel_w(N)
) (
  input  logic [N-1:0]    req_valid,
  input  logic [SelW-1:0] ptr,
  output logic [SelW-1:0] g,
  output logic            gnt_vld
);

  int unsigned idx;

  always_comb begin
    g       = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr < N always, so one subtraction keeps idx in range without a modulo.
      idx = 32'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!gnt_vld && req_valid[SelW'(idx)]) begin
        g       = SelW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 mux between N valid/ready requesters,
// feeding a single-entry registered output buffer.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned SelW = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SelW-1:0]    out_sel,
  input  logic               out_ready
);

  buf_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [SelW-1:0]   ptr_q, ptr_d;

  logic [SelW-1:0]   g;
  logic              gnt_vld;
  logic [WIDTH-1:0]  mux_data;
  logic              ld;
  logic              accept;

  rr_grant #(
    .N (N)
  ) u_rr_grant (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .g         (g),
    .gnt_vld   (gnt_vld)
  );

  n_1_mux #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_n_1_mux (
    .in_data  (req_data),
    .sel      (g),
    .out_data (mux_data)
  );

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Buffer can take a word when empty or when its current word leaves this cycle.
  assign ld     = !out_valid || out_ready;
  assign accept = ld && gnt_vld;

  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[g] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (ld) begin
      if (gnt_vld) begin
        state_d = StFull;
        data_d  = mux_data;
        sel_d   = g;
        ptr_d   = (g == SelW'(N - 1)) ? '0 : g + SelW'(1);
      end else begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: vector table on an N=4 instance, a scoreboard on its output
// stream, and hand sequences for wrap, backpressure and mid-operation reset (N=3 too).
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [2:0]  vld3;
  logic [11:0] data3;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [3:0]  od3;
  logic [1:0]  os3;
  logic        ordy3;

  int n_chk  = 0;
  int n_fail = 0;

  rr_mux_arbiter #(
    .N     (4),
    .WIDTH (4)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_arbiter #(
    .N     (3),
    .WIDTH (4)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (vld3),
    .req_data  (data3),
    .req_ready (rdy3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_ready (ordy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: {sel, data} pushed on each accepted handshake, popped on each drain.
  logic [5:0] sb_q[$];
  logic [5:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      chk("rdy_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got word 0x%0h sel %0d, expected none", out_data, out_sel);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_word", 32'({out_sel, out_data}), 32'(exp_e));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          sb_q.push_back({2'(i), req_data[i*4 +: 4]});
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  vld;
    logic        ordy;
    logic [15:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_od;
  } row_t;

  row_t rows [22];

  initial begin
    // Outputs expected are those visible during the row's cycle (result of earlier rows).
    rows = '{
      '{4'hF, 1'b1, 16'hDCBA, 4'b0001, 1'b0, 2'd0, 4'h0},
      '{4'hF, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd0, 4'hA},
      '{4'hF, 1'b1, 16'hDCBA, 4'b0100, 1'b1, 2'd1, 4'hB},
      '{4'hF, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd2, 4'hC},
      '{4'hF, 1'b1, 16'hDCBA, 4'b0001, 1'b1, 2'd3, 4'hD},
      '{4'hA, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd0, 4'hA},
      '{4'hA, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd1, 4'hB},
      '{4'hA, 1'b1, 16'hDCBA, 4'b0010, 1'b1, 2'd3, 4'hD},
      '{4'hA, 1'b1, 16'hDCBA, 4'b1000, 1'b1, 2'd1, 4'hB},
      '{4'h0, 1'b1, 16'hDCBA, 4'b0000, 1'b1, 2'd3, 4'hD},
      '{4'h0, 1'b1, 16'hDCBA, 4'b0000, 1'b0, 2'd3, 4'hD},
      '{4'h4, 1'b0, 16'h0500, 4'b0100, 1'b0, 2'd3, 4'hD},
      '{4'hF, 1'b0, 16'h0500, 4'b0000, 1'b1, 2'd2, 4'h5},
      '{4'hF, 1'b0, 16'h0500, 4'b0000, 1'b1, 2'd2, 4'h5},
      '{4'hF, 1'b0, 16'h0500, 4'b0000, 1'b1, 2'd2, 4'h5},
      '{4'hF, 1'b1, 16'h0500, 4'b1000, 1'b1, 2'd2, 4'h5},
      '{4'h0, 1'b1, 16'h0500, 4'b0000, 1'b1, 2'd3, 4'h0},
      '{4'h1, 1'b1, 16'h0007, 4'b0001, 1'b0, 2'd3, 4'h0},
      '{4'h0, 1'b1, 16'h0007, 4'b0000, 1'b1, 2'd0, 4'h7},
      '{4'h0, 1'b1, 16'h0007, 4'b0000, 1'b0, 2'd0, 4'h7},
      '{4'hF, 1'b1, 16'hDCBA, 4'b0010, 1'b0, 2'd0, 4'h7},
      '{4'h0, 1'b0, 16'hDCBA, 4'b0000, 1'b1, 2'd1, 4'hB}
    };

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'hDCBA;
    out_ready = 1'b1;
    vld3      = 3'b111;
    data3     = 12'h321;
    ordy3     = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'd0);
    chk("rst_os", 32'(out_sel), 32'd0);
    chk("rst_rdy3", 32'(rdy3), 32'd0);
    chk("rst_ov3", 32'(ov3), 32'd0);
    req_valid = 4'h0;
    vld3      = 3'b000;
    rst_n     = 1'b1;

    for (int r = 0; r < 22; r++) begin
      @(posedge clk);
      #1;
      req_valid = rows[r].vld;
      out_ready = rows[r].ordy;
      req_data  = rows[r].data;
      @(negedge clk);
      chk($sformatf("row%0d_rdy", r), 32'(req_ready), 32'(rows[r].exp_rdy));
      chk($sformatf("row%0d_ov", r), 32'(out_valid), 32'(rows[r].exp_ov));
      chk($sformatf("row%0d_os", r), 32'(out_sel), 32'(rows[r].exp_sel));
      chk($sformatf("row%0d_od", r), 32'(out_data), 32'(rows[r].exp_od));
    end

    // N=3: all requesting, grants wrap 2 -> 0; dut4 is held FULL and stalled meanwhile.
    for (int k = 0; k < 7; k++) begin
      logic [2:0] e3;
      @(posedge clk);
      #1;
      vld3  = 3'b111;
      ordy3 = 1'b1;
      @(negedge clk);
      e3 = 3'b001 << (k % 3);
      chk($sformatf("n3_rdy%0d", k), 32'(rdy3), 32'(e3));
      chk($sformatf("n3_range%0d", k), 32'(os3 < 2'd3), 32'd1);
      if (k > 0) begin
        chk($sformatf("n3_ov%0d", k), 32'(ov3), 32'd1);
        chk($sformatf("n3_os%0d", k), 32'(os3), 32'((k - 1) % 3));
        chk($sformatf("n3_od%0d", k), 32'(od3), 32'((k - 1) % 3 + 1));
      end
    end
    @(posedge clk);
    #1;
    ordy3 = 1'b0;
    @(negedge clk);
    chk("n3_full_ov", 32'(ov3), 32'd1);
    chk("n3_full_os", 32'(os3), 32'd0);
    chk("n3_full_od", 32'(od3), 32'd1);
    chk("n3_full_rdy", 32'(rdy3), 32'd0);
    chk("n4_hold_ov", 32'(out_valid), 32'd1);
    chk("n4_hold_od", 32'(out_data), 32'hB);

    // Reset while both buffers are FULL: outputs clear asynchronously.
    @(posedge clk);
    #2;
    req_valid = 4'hF;
    vld3      = 3'b111;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_od", 32'(out_data), 32'd0);
    chk("mid_rst_os", 32'(out_sel), 32'd0);
    chk("mid_rst_rdy", 32'(req_ready), 32'd0);
    chk("mid_rst_ov3", 32'(ov3), 32'd0);
    chk("mid_rst_os3", 32'(os3), 32'd0);
    chk("mid_rst_rdy3", 32'(rdy3), 32'd0);
    @(negedge clk);
    #2;
    req_valid = 4'h0;
    vld3      = 3'b000;
    rst_n     = 1'b1;

    @(posedge clk);
    #1;
    req_valid = 4'hF;
    req_data  = 16'hDCBA;
    out_ready = 1'b1;
    vld3      = 3'b111;
    ordy3     = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(req_ready), 32'b0001);
    chk("post_rst_rdy3", 32'(rdy3), 32'b001);
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    vld3      = 3'b000;
    @(negedge clk);
    chk("post_rst_ov", 32'(out_valid), 32'd1);
    chk("post_rst_os", 32'(out_sel), 32'd0);
    chk("post_rst_od", 32'(out_data), 32'hA);
    chk("post_rst_os3", 32'(os3), 32'd0);
    chk("post_rst_od3", 32'(od3), 32'd1);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
